// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: instruction field positions, fetch constants
// and the fetch FSM state type.
package cpu_pkg;

    localparam int unsigned INSTR_W   = 32;

    localparam int unsigned OPC_MSB   = 31;
    localparam int unsigned OPC_LSB   = 26;
    localparam int unsigned FUNCT_MSB = 5;
    localparam int unsigned FUNCT_LSB = 0;
    localparam int unsigned RS_MSB    = 25;
    localparam int unsigned RS_LSB    = 21;
    localparam int unsigned RT_MSB    = 20;
    localparam int unsigned RT_LSB    = 16;
    localparam int unsigned RD_MSB    = 15;
    localparam int unsigned RD_LSB    = 11;
    localparam int unsigned IMM_MSB   = 15;
    localparam int unsigned IMM_LSB   = 0;

    localparam int unsigned PC_STEP   = 4;

    localparam logic [INSTR_W-1:0] NOP_INSTR = '0;

    // IDLE: nothing outstanding; REQ: live request; FLUSH: request outstanding
    // whose returning word must be dropped.
    typedef enum logic [1:0] {
        IDLE,
        REQ,
        FLUSH
    } fetch_state_e;

endpackage

// File: rtl/fetch_buffer.sv
// Synchronous prefetch FIFO holding {pc, instruction} pairs. Flush overrides
// any push or pop in the same cycle. DEPTH must be a power of two.
module fetch_buffer #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;

    // Storage array: written on an accepted push, contents need no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // Pointer and occupancy bookkeeping; flush empties the buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: owns the PC, keeps one read outstanding to
// instruction memory, buffers returned words and issues them with decoded
// fields to the decoder. Redirect flushes buffered and in-flight words.
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int unsigned        ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0,
    parameter int unsigned        DEPTH    = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [31:0]        imem_rdata,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               issue_valid,
    input  logic               issue_ready,
    output logic [31:0]        issue_instr,
    output logic [ADDR_W-1:0]  issue_pc,
    output logic [5:0]         opcode,
    output logic [5:0]         funct,
    output logic [4:0]         rs,
    output logic [4:0]         rt,
    output logic [4:0]         rd,
    output logic [15:0]        imm
);

    localparam int unsigned ENTRY_W = ADDR_W + INSTR_W;
    localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    logic               buf_push, buf_full, buf_empty, pop_fire;
    logic [CNT_W-1:0]   buf_count, count_after;
    logic [ENTRY_W-1:0] head;
    logic [ADDR_W-1:0]  redirect_aligned, next_pc;

    assign redirect_aligned = redirect_pc & ~ADDR_W'(3);
    assign next_pc          = fetch_pc_q + ADDR_W'(PC_STEP);

    assign issue_valid = !buf_empty;
    assign pop_fire    = issue_valid && issue_ready && !redirect_valid;
    // Occupancy once this cycle's pop and the incoming word are both applied.
    assign count_after = buf_count + CNT_W'(1) - CNT_W'(pop_fire);

    fetch_buffer #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (buf_push),
        .data_i  ({fetch_pc_q, imem_rdata}),
        .pop_i   (pop_fire),
        .flush_i (redirect_valid),
        .data_o  (head),
        .full_o  (buf_full),
        .empty_o (buf_empty),
        .count_o (buf_count)
    );

    // Fetch FSM, PC and request-address registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            addr_q     <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
        end
    end

    // Next-state logic: redirect first, then ack handling / request launch.
    // fetch_pc moves to the redirect target at once, while addr_q keeps the
    // outstanding request address until the memory acknowledges it.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        addr_d     = addr_q;
        buf_push   = 1'b0;
        case (state_q)
            IDLE: begin
                if (redirect_valid) begin
                    fetch_pc_d = redirect_aligned;
                end else if (!buf_full) begin
                    state_d = REQ;
                    addr_d  = fetch_pc_q;
                end
            end
            REQ: begin
                if (redirect_valid) begin
                    fetch_pc_d = redirect_aligned;
                    if (imem_ack) begin
                        addr_d = redirect_aligned;
                    end else begin
                        state_d = FLUSH;
                    end
                end else if (imem_ack) begin
                    buf_push   = 1'b1;
                    fetch_pc_d = next_pc;
                    if (count_after < CNT_W'(DEPTH)) begin
                        addr_d = next_pc;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            FLUSH: begin
                if (redirect_valid) begin
                    fetch_pc_d = redirect_aligned;
                end
                if (imem_ack) begin
                    state_d = REQ;
                    addr_d  = redirect_valid ? redirect_aligned : fetch_pc_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign imem_req  = (state_q != IDLE);
    assign imem_addr = addr_q;

    assign issue_instr = issue_valid ? head[INSTR_W-1:0]       : NOP_INSTR;
    assign issue_pc    = issue_valid ? head[ENTRY_W-1:INSTR_W] : '0;

    assign opcode = issue_instr[OPC_MSB:OPC_LSB];
    assign funct  = issue_instr[FUNCT_MSB:FUNCT_LSB];
    assign rs     = issue_instr[RS_MSB:RS_LSB];
    assign rt     = issue_instr[RT_MSB:RT_LSB];
    assign rd     = issue_instr[RD_MSB:RD_LSB];
    assign imm    = issue_instr[IMM_MSB:IMM_LSB];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: a memory responder with programmable ack
// latency, a scoreboard of the expected instruction stream (sequential PCs
// restarting at every redirect target) and directed plus randomized phases.
module tb_instr_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk, rst_n;
    logic        imem_req, imem_ack;
    logic [31:0] imem_addr, imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        issue_valid, issue_ready;
    logic [31:0] issue_instr, issue_pc;
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;

    instr_fetch_unit #(
        .ADDR_W   (32),
        .RESET_PC (RESET_PC),
        .DEPTH    (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .issue_valid    (issue_valid),
        .issue_ready    (issue_ready),
        .issue_instr    (issue_instr),
        .issue_pc       (issue_pc),
        .opcode         (opcode),
        .funct          (funct),
        .rs             (rs),
        .rt             (rt),
        .rd             (rd),
        .imm            (imm)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_tests = 0;
    int n_fail  = 0;
    int n_pop   = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] gen_pc;
    logic [31:0] salt;
    bit          decode_mode;
    int unsigned fixed_delay;
    bit          rand_delay;
    logic [31:0] slow_addr;
    int unsigned slow_delay;

    // Memory contents seen by the fetch unit.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (decode_mode && a == 32'h0) return 32'h0000_0020;
        if (decode_mode && a == 32'h4) return 32'h8C22_0004;
        return a ^ salt;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic refill();
        exp_t e;
        while (exp_q.size() < 8) begin
            e.pc    = gen_pc;
            e.instr = mem_word(gen_pc);
            exp_q.push_back(e);
            gen_pc  = gen_pc + 32'd4;
        end
    endtask

    task automatic restart(input logic [31:0] pc);
        exp_q.delete();
        gen_pc = pc & ~32'h3;
        refill();
    endtask

    task automatic do_reset(input logic [31:0] s, input bit dm);
        rst_n          = 1'b0;
        issue_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        salt           = s;
        decode_mode    = dm;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #2;
        restart(RESET_PC);
        rst_n = 1'b1;
    endtask

    // Memory responder: one request at a time, ack after a chosen number of
    // wait cycles (0 = same cycle as the request is seen).
    initial begin
        bit          busy;
        int unsigned wait_n;
        logic [31:0] busy_addr;
        busy       = 1'b0;
        wait_n     = 0;
        busy_addr  = '0;
        imem_ack   = 1'b0;
        imem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n || !imem_req) begin
                if (busy && rst_n) check("req_held_until_ack", imem_req, 1);
                busy     = 1'b0;
                imem_ack = 1'b0;
            end else begin
                if (!busy) begin
                    busy      = 1'b1;
                    busy_addr = imem_addr;
                    if (imem_addr == slow_addr) wait_n = slow_delay;
                    else if (rand_delay)        wait_n = $urandom_range(3, 0);
                    else                        wait_n = fixed_delay;
                end else begin
                    check("addr_stable", imem_addr, busy_addr);
                end
                if (wait_n == 0) begin
                    imem_ack   = 1'b1;
                    imem_rdata = mem_word(imem_addr);
                    busy       = 1'b0;
                end else begin
                    imem_ack   = 1'b0;
                    imem_rdata = $urandom;
                    wait_n--;
                end
            end
        end
    end

    // Monitor / scoreboard: compares the presented head against the expected
    // stream and pops on acceptance.
    initial begin
        bit   redir_prev, ack_prev, disc_pend;
        exp_t e;
        redir_prev = 1'b0;
        ack_prev   = 1'b0;
        disc_pend  = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                check("rst_req", imem_req, 0);
                check("rst_addr", imem_addr, RESET_PC);
                check("rst_valid", issue_valid, 0);
                check("rst_instr", issue_instr, 0);
                check("rst_pc", issue_pc, 0);
                check("rst_fields_a", {opcode, funct, rs, rt}, 0);
                check("rst_fields_b", {rd, imm}, 0);
                redir_prev = 1'b0;
                ack_prev   = 1'b0;
                disc_pend  = 1'b0;
            end else begin
                if (redir_prev) check("valid_after_redirect", issue_valid, 0);
                if (ack_prev)   check("valid_after_ack", issue_valid, 1);
                if (!issue_valid) begin
                    check("empty_instr", issue_instr, 0);
                    check("empty_pc", issue_pc, 0);
                    check("empty_fields_a", {opcode, funct, rs, rt}, 0);
                    check("empty_fields_b", {rd, imm}, 0);
                end else if (!redirect_valid) begin
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL scoreboard_empty: actual=pc 0x%0h required=no instruction", issue_pc);
                    end else begin
                        e = exp_q[0];
                        check("issue_pc", issue_pc, e.pc);
                        check("issue_instr", issue_instr, e.instr);
                        check("opcode", opcode, e.instr[31:26]);
                        check("funct", funct, e.instr[5:0]);
                        check("rs", rs, e.instr[25:21]);
                        check("rt", rt, e.instr[20:16]);
                        check("rd", rd, e.instr[15:11]);
                        check("imm", imm, e.instr[15:0]);
                        if (issue_ready) begin
                            void'(exp_q.pop_front());
                            n_pop++;
                            refill();
                        end
                    end
                end
                ack_prev = 1'b0;
                if (redirect_valid) begin
                    disc_pend = imem_req && !imem_ack;
                end else if (imem_req && imem_ack) begin
                    if (disc_pend) disc_pend = 1'b0;
                    else           ack_prev  = 1'b1;
                end
                redir_prev = redirect_valid;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual=still running required=finished at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n0;
        bit found;
        rst_n          = 1'b0;
        issue_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        fixed_delay    = 0;
        rand_delay     = 1'b0;
        slow_addr      = 32'hFFFF_FFFF;
        slow_delay     = 0;
        salt           = '0;
        decode_mode    = 1'b0;

        // Streaming with ack and ready tied high, data = address.
        do_reset(32'h0, 1'b0);
        issue_ready = 1'b1;
        @(posedge clk); #3;
        check("p1_first_req", imem_req, 1);
        check("p1_first_addr", imem_addr, 32'h0);
        check("p1_not_valid_yet", issue_valid, 0);
        @(posedge clk); #3;
        check("p1_first_valid", issue_valid, 1);
        check("p1_pc0", issue_pc, 32'h0);
        check("p1_instr0", issue_instr, 32'h0);
        @(posedge clk); #3;
        check("p1_pc4", issue_pc, 32'h4);
        check("p1_instr4", issue_instr, 32'h4);
        check("p1_addr8", imem_addr, 32'h8);
        @(posedge clk); #3;
        check("p1_pc8", issue_pc, 32'h8);
        n0 = n_pop;
        repeat (20) @(posedge clk);
        #3;
        check("p1_throughput", n_pop - n0, 20);

        // Decoder stalled: buffer fills, request stops, one pop relaunches.
        do_reset(32'h0, 1'b0);
        repeat (5) @(posedge clk);
        #3;
        check("p2_req_stopped", imem_req, 0);
        check("p2_valid", issue_valid, 1);
        check("p2_head_pc", issue_pc, 32'h0);
        @(posedge clk); #2;
        issue_ready = 1'b1;
        @(posedge clk); #2;
        issue_ready = 1'b0;
        #1;
        check("p2_no_same_edge_launch", imem_req, 0);
        check("p2_head_after_pop", issue_pc, 32'h4);
        @(posedge clk); #3;
        check("p2_launch", imem_req, 1);
        check("p2_launch_addr", imem_addr, 32'h8);

        // Ack delayed by three cycles: one word every four cycles.
        fixed_delay = 3;
        do_reset(32'h0, 1'b0);
        issue_ready = 1'b1;
        n0 = n_pop;
        repeat (40) @(posedge clk);
        #3;
        check("p3_slow_rate", n_pop - n0, 9);
        fixed_delay = 0;

        // Field decode of known encodings.
        do_reset(32'h0, 1'b1);
        issue_ready = 1'b1;
        @(posedge clk);
        @(posedge clk); #3;
        check("p4_add_opcode", opcode, 6'h00);
        check("p4_add_funct", funct, 6'h20);
        @(posedge clk); #3;
        check("p4_lw_opcode", opcode, 6'h23);
        check("p4_lw_rs", rs, 5'd1);
        check("p4_lw_rt", rt, 5'd2);
        check("p4_lw_imm", imm, 16'h0004);

        // Redirect while the request to 0x8 is still waiting for its ack.
        slow_addr  = 32'h8;
        slow_delay = 2;
        do_reset(32'h0, 1'b0);
        issue_ready = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(posedge clk); #3;
            if (imem_req && imem_addr == 32'h8) found = 1'b1;
        end
        check("p5_req8_seen", found, 1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h103;
        restart(32'h103);
        @(posedge clk); #2;
        redirect_valid = 1'b0;
        #1;
        check("p5_addr_held", imem_addr, 32'h8);
        check("p5_flushed", issue_valid, 0);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(posedge clk); #3;
            if (imem_addr != 32'h8) found = 1'b1;
        end
        check("p5_new_addr", imem_addr, 32'h100);
        check("p5_new_req", imem_req, 1);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (issue_valid) found = 1'b1;
            else begin @(posedge clk); #3; end
        end
        check("p5_first_after_redirect", issue_pc, 32'h100);
        slow_addr = 32'hFFFF_FFFF;

        // Redirect coinciding with an ack and a pop.
        slow_addr  = 32'h4;
        slow_delay = 2;
        do_reset(32'h0, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(posedge clk); #3;
            if (imem_req && imem_ack && imem_addr == 32'h4) found = 1'b1;
        end
        check("p6_ack4_seen", found, 1);
        issue_ready    = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        restart(32'h40);
        @(posedge clk); #2;
        issue_ready    = 1'b0;
        redirect_valid = 1'b0;
        #1;
        check("p6_empty", issue_valid, 0);
        check("p6_req", imem_req, 1);
        check("p6_addr", imem_addr, 32'h40);
        issue_ready = 1'b1;
        repeat (10) @(posedge clk);
        slow_addr = 32'hFFFF_FFFF;

        // Randomized traffic: latency, ready, redirects (incl. near wrap), reset.
        rand_delay = 1'b1;
        do_reset($urandom, 1'b0);
        n0 = n_pop;
        @(posedge clk); #2;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF6;
        restart(redirect_pc);
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(posedge clk); #2;
            issue_ready = ($urandom_range(9, 0) < 7);
            if (cyc == 1500) begin
                rst_n          = 1'b0;
                redirect_valid = 1'b0;
                #1;
                check("mid_reset_req", imem_req, 0);
                check("mid_reset_valid", issue_valid, 0);
                exp_q.delete();
                @(posedge clk);
                @(posedge clk); #2;
                restart(RESET_PC);
                rst_n = 1'b1;
            end else if ($urandom_range(15, 0) == 0) begin
                redirect_valid = 1'b1;
                redirect_pc    = $urandom_range(1, 0) ? $urandom : (32'hFFFF_FFE0 | $urandom_range(31, 0));
                restart(redirect_pc);
            end else begin
                redirect_valid = 1'b0;
            end
        end
        @(posedge clk); #2;
        redirect_valid = 1'b0;
        issue_ready    = 1'b1;
        repeat (20) @(posedge clk);
        #3;
        check("p7_progress", (n_pop - n0) > 200, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
